// File: rtl/mips32_pkg.sv
// Shared mips32 core constants: memory-port arbiter state encoding,
// grant identifiers and the default busy-state timeout.
package mips32_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } arb_gnt_e;

    localparam int unsigned ARB_TIMEOUT_CYC = 15;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle counter for the memory-port arbiter; expired_o is high
// during the LIMIT-th consecutive enabled cycle.
module arb_timeout_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = en_i & (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and the MEM stage.
// Optional busy-state timeout abort is enabled with `define ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                stall_pipe,
    output logic                stall_if,
    output logic                err
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic              fair_q, fair_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ok, dm_ok;
    logic              busy, expired, finish;
    logic [DATA_W-1:0] fin_data;
    arb_gnt_e          gnt;

    assign busy = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
    logic err_q;

    arb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (~busy),
        .en_i      (busy),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (expired && !mem_ready) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    // A port whose ack is showing this cycle still has its old req up; skip it.
    assign if_ok    = if_req & ~if_ack_q;
    assign dm_ok    = dm_req & ~dm_ack_q;
    assign finish   = busy & (mem_ready | expired);
    assign fin_data = mem_ready ? mem_rdata : '0;

    always_comb begin
        state_d     = state_q;
        fair_d      = fair_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt         = GNT_NONE;

        unique case (state_q)
            IDLE: begin
                if (if_ok && (fair_q || !dm_ok)) begin
                    gnt = GNT_IF;
                end else if (dm_ok) begin
                    gnt = GNT_DM;
                end

                if (gnt == GNT_IF) begin
                    state_d     = IF_BUSY;
                    fair_d      = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end else if (gnt == GNT_DM) begin
                    state_d     = DM_BUSY;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end
            end
            IF_BUSY: begin
                if (finish) begin
                    state_d    = IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = fin_data;
                end
            end
            DM_BUSY: begin
                if (finish) begin
                    state_d    = IDLE;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = fin_data;
                    fair_d     = fair_q | if_req;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fair_q      <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            fair_q      <= fair_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stalls are forced low while reset is held so every output reads 0 in reset.
    assign stall_pipe = dm_req & ~dm_ack_q & ~rst;
    assign stall_if   = ((if_req & ~if_ack_q) & ~rst) | stall_pipe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO    = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 15;
    localparam bit          TO_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          if_req, if_ack, dm_req, dm_we, dm_ack;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
    logic [BW-1:0] dm_be, mem_be;
    logic          mem_req, mem_we, mem_ready, stall_pipe, stall_if, err;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_be      (dm_be),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall_pipe (stall_pipe),
        .stall_if   (stall_if),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Transaction-level model: who owns the port, the fairness debt, and the
    // results each requester sees.
    int            m_owner;   // 0 none, 1 fetch, 2 data
    int            m_cnt;
    bit            m_fair, m_if_ack, m_dm_ack, m_err;
    logic [DW-1:0] m_if_rdata, m_dm_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [BW-1:0] m_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_fair = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
        m_if_rdata = '0; m_dm_rdata = '0; m_wdata = '0; m_addr = '0; m_we = 0; m_be = '0;
    endtask

    task automatic model_step();
        bit            ifok, dmok, done;
        logic [DW-1:0] d;
        ifok = if_req && !m_if_ack;
        dmok = dm_req && !m_dm_ack;
        m_if_ack = 0;
        m_dm_ack = 0;
        if (m_owner == 0) begin
            m_cnt = 0;
            if (ifok && (m_fair || !dmok)) begin
                m_owner = 1; m_fair = 0;
                m_addr = if_addr; m_wdata = '0; m_we = 0; m_be = '0;
            end else if (dmok) begin
                m_owner = 2;
                m_addr = dm_addr; m_wdata = dm_wdata; m_we = dm_we; m_be = dm_be;
            end
        end else begin
            m_cnt++;
            done = mem_ready || (TO_EN && m_cnt == int'(TO));
            if (done) begin
                d = mem_ready ? mem_rdata : '0;
                if (!mem_ready) m_err = 1;
                if (m_owner == 1) begin
                    m_if_ack = 1; m_if_rdata = d;
                end else begin
                    m_dm_ack = 1; m_dm_rdata = d;
                    if (if_req) m_fair = 1;
                end
                m_owner = 0;
            end
        end
    endtask

    // Model advances on the active edge; inputs change 2 time units later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req",    mem_req,    m_owner != 0);
            check("mem_addr",   mem_addr,   m_addr);
            check("mem_wdata",  mem_wdata,  m_wdata);
            check("mem_we",     mem_we,     m_we);
            check("mem_be",     mem_be,     m_be);
            check("if_ack",     if_ack,     m_if_ack);
            check("dm_ack",     dm_ack,     m_dm_ack);
            check("if_rdata",   if_rdata,   m_if_rdata);
            check("dm_rdata",   dm_rdata,   m_dm_rdata);
            check("err",        err,        m_err);
            check("stall_pipe", stall_pipe, !rst && dm_req && !m_dm_ack);
            check("stall_if",   stall_if,   !rst && ((if_req && !m_if_ack) || (dm_req && !m_dm_ack)));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_be = '0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 0;
        model_reset();
        repeat (2) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ack",  if_ack,  0);
        check("rst_dm_ack",  dm_ack,  0);
        check("rst_err",     err,     0);
        check("rst_mem_addr", mem_addr, 0);
        chk_en = 1;
        rst = 0;
        tick();

        // Load, no contention
        tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        #1 check("load_stall_c0", stall_pipe, 1);
        tick(); check("load_mem_req_c1", mem_req, 1); check("load_addr_c1", mem_addr, 32'h100);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1 check("load_stall_c1", stall_pipe, 1);
        tick(); check("load_ack_c2", dm_ack, 1); check("load_rdata", dm_rdata, 32'hDEADBEEF);
        check("load_mem_req_c2", mem_req, 0);
        dm_req = 0; mem_ready = 0;
        tick();

        // Store with three wait cycles
        tick(); dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_wdata = 32'h12345678; dm_addr = 32'h200;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("store_mem_req", mem_req, 1);
            check("store_we", mem_we, 1);
            check("store_be", mem_be, 4'b0011);
            check("store_wdata", mem_wdata, 32'h12345678);
            check("store_addr", mem_addr, 32'h200);
            if (i == 4) mem_ready = 1;
        end
        tick(); check("store_ack_c5", dm_ack, 1);
        dm_req = 0; dm_we = 0; dm_be = '0; mem_ready = 0;
        tick();

        // Contention, fairness and stale fetch request
        tick(); if_req = 1; if_addr = 32'h40; dm_req = 1; dm_addr = 32'h300;
        tick(); check("cont_dm_first", mem_addr, 32'h300); mem_ready = 1; mem_rdata = 32'hA1;
        tick(); check("cont_dm_ack", dm_ack, 1); dm_addr = 32'h304; mem_ready = 0;
        tick(); check("fair_if_granted", mem_addr, 32'h40); check("fair_if_we", mem_we, 0);
        mem_ready = 1; mem_rdata = 32'hB2;
        tick(); check("fair_if_ack", if_ack, 1); check("fair_if_rdata", if_rdata, 32'hB2);
        mem_ready = 0;
        tick(); check("stale_if_skipped", mem_addr, 32'h304); if_req = 0; mem_ready = 1; mem_rdata = 32'hC3;
        tick(); check("cont_dm2_rdata", dm_rdata, 32'hC3); dm_req = 0; mem_ready = 0;
        tick();

        // Stale fetch request alone
        tick(); if_req = 1; if_addr = 32'h80;
        tick(); mem_ready = 1; mem_rdata = 32'h55;
        tick(); check("stale_ack", if_ack, 1); mem_ready = 0;
        tick(); check("stale_no_regrant", mem_req, 0); if_req = 0;
        tick();

        // Asynchronous reset mid-transaction
        tick(); dm_req = 1; dm_addr = 32'h400;
        tick(); check("arst_busy", mem_req, 1);
        #1 rst = 1; model_reset();
        #1 check("arst_mem_req", mem_req, 0); check("arst_stall_pipe", stall_pipe, 0);
        check("arst_stall_if", stall_if, 0); check("arst_dm_ack", dm_ack, 0);
        check("arst_fields", mem_addr, 0);
        tick(); dm_req = 0;
        tick(); rst = 0;
        repeat (3) tick();
        check("arst_no_ack", dm_ack, 0);

`ifdef ARB_TIMEOUT_EN
        tick(); dm_req = 1; dm_addr = 32'h500; mem_ready = 0;
        repeat (4) begin tick(); check("to_busy", mem_req, 1); end
        tick(); check("to_ack", dm_ack, 1); check("to_rdata", dm_rdata, 0); check("to_err", err, 1);
        dm_req = 0;
        repeat (3) tick();
        check("to_err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (if_req) begin
                if (m_if_ack) if_req = ($urandom_range(3) == 0);
            end else if ($urandom_range(2) == 0) begin
                if_req = 1; if_addr = {$urandom} & 32'hFFFF_FFFC;
            end
            if (dm_req) begin
                if (m_dm_ack) dm_req = ($urandom_range(3) == 0);
            end else if ($urandom_range(2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(1); dm_be = BW'($urandom);
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            mem_ready = ($urandom_range(4) < 2);
            mem_rdata = $urandom;
        end
        if_req = 0; dm_req = 0; mem_ready = 1;
        repeat (4) tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
